// File: rtl/block_interleaver_wide.sv
// block_interleaver_wide
//   Ping-pong block interleaver / deinterleaver between two FWFT FIFOs.
//   A block of N = ROW_NUMBER*COL_NUMBER symbols is written into one of two
//   buffers while the other is drained. Interleave writes row-major and reads
//   column-major; deinterleave writes column-major and reads row-major. The
//   direction is taken from MODE at the first symbol of each block.
//
// Ports
//   CLK            rising-edge clock
//   RESET          synchronous, active-high reset
//   MODE           0 = interleave, 1 = deinterleave (latched per block)
//   FIFO_IN_DATA   input symbol (first-word-fall-through)
//   FIFO_IN_EMPTY  input FIFO empty
//   FIFO_IN_RE     input read strobe (combinational)
//   FIFO_OUT_DATA  output symbol (registered)
//   FIFO_OUT_WE    output write strobe (registered)
//   FIFO_OUT_FULL  output FIFO almost-full (gates read issue only)
//   BLOCK_END      pulse with the FIFO_OUT_WE of the last symbol of a block
module block_interleaver_wide #(
  parameter int ROW_NUMBER = 10,
  parameter int COL_NUMBER = 7,
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = $clog2(ROW_NUMBER * COL_NUMBER)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MODE,
  input  logic [DATA_WIDTH-1:0] FIFO_IN_DATA,
  input  logic                  FIFO_IN_EMPTY,
  output logic                  FIFO_IN_RE,
  output logic [DATA_WIDTH-1:0] FIFO_OUT_DATA,
  output logic                  FIFO_OUT_WE,
  input  logic                  FIFO_OUT_FULL,
  output logic                  BLOCK_END
);

  localparam int N = ROW_NUMBER * COL_NUMBER;
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(ROW_NUMBER - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(COL_NUMBER - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_W    = ADDR_WIDTH'(COL_NUMBER);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] r;
    logic [ADDR_WIDTH-1:0] c;
  } pos_t;

  // Step a (row, col) position. row_first=1 walks the matrix column-major
  // (row counter runs fastest), otherwise row-major. The wrap after the last
  // element is never used: both sides clear their counters at the block end.
  function automatic pos_t advance(input pos_t p, input logic row_first);
    pos_t n;
    n = p;
    if (row_first) begin
      if (p.r == ROW_LAST) begin
        n.r = '0;
        n.c = p.c + ONE;
      end else begin
        n.r = p.r + ONE;
      end
    end else begin
      if (p.c == COL_LAST) begin
        n.c = '0;
        n.r = p.r + ONE;
      end else begin
        n.c = p.c + ONE;
      end
    end
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2][N];

  logic [1:0]            full;
  logic [1:0]            mode_bit;
  logic                  wr_sel;
  logic                  rd_sel;
  pos_t                  wr_pos;
  pos_t                  rd_pos;

  logic                  wr_en;
  logic                  wr_mode;
  logic                  wr_last;
  logic [ADDR_WIDTH-1:0] wr_addr;
  pos_t                  wr_pos_nxt;
  logic                  rd_issue;
  logic                  rd_last;
  logic [ADDR_WIDTH-1:0] rd_addr;
  pos_t                  rd_pos_nxt;

  // Both traversal orders address the buffer as r*COL+c; only the order in
  // which r and c advance differs between writer and reader.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_en      = !FIFO_IN_EMPTY && !full[wr_sel] && !RESET;
    // The first symbol of a block sees counters at zero and uses MODE
    // directly; the latched copy is only valid from the next cycle on.
    wr_mode    = ((wr_pos.r == '0) && (wr_pos.c == '0)) ? MODE : mode_bit[wr_sel];
    wr_last    = (wr_pos.r == ROW_LAST) && (wr_pos.c == COL_LAST);
    wr_addr    = wr_pos.r * COL_W + wr_pos.c;
    wr_pos_nxt = advance(wr_pos, wr_mode);

    rd_issue   = full[rd_sel] && !FIFO_OUT_FULL;
    rd_last    = (rd_pos.r == ROW_LAST) && (rd_pos.c == COL_LAST);
    rd_addr    = rd_pos.r * COL_W + rd_pos.c;
    rd_pos_nxt = advance(rd_pos, !mode_bit[rd_sel]);
  end

  assign FIFO_IN_RE = wr_en;

  // NOTE: the symbol store has no reset; its contents are only ever read
  // after a complete block has been written, so reset just clears the flags.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_sel][wr_addr] <= FIFO_IN_DATA;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // right-hand side below sees the values from before this edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      full          <= '0;
      mode_bit      <= '0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      wr_pos        <= '0;
      rd_pos        <= '0;
      FIFO_OUT_WE   <= 1'b0;
      FIFO_OUT_DATA <= '0;
      BLOCK_END     <= 1'b0;
    end else begin
      if (wr_en) begin
        if ((wr_pos.r == '0) && (wr_pos.c == '0)) begin
          mode_bit[wr_sel] <= MODE;
        end
        if (wr_last) begin
          full[wr_sel] <= 1'b1;
          wr_pos       <= '0;
          wr_sel       <= ~wr_sel;
        end else begin
          wr_pos <= wr_pos_nxt;
        end
      end

      // Writer only touches a non-full buffer and the reader only a full
      // one, so the two full[] updates never target the same bit.
      FIFO_OUT_WE <= rd_issue;
      BLOCK_END   <= rd_issue && rd_last;
      if (rd_issue) begin
        FIFO_OUT_DATA <= mem[rd_sel][rd_addr];
        if (rd_last) begin
          full[rd_sel] <= 1'b0;
          rd_pos       <= '0;
          rd_sel       <= ~rd_sel;
        end else begin
          rd_pos <= rd_pos_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_interleaver_wide.sv
// tb_block_interleaver_wide
//   Directed sequence of scenarios with randomized data/backpressure. The
//   reference model collects each consumed block and produces its permuted
//   output from index arithmetic (out[j] = in[(j%R)*C + j/R] for interleave,
//   out[(k%R)*C + k/R] = in[k] for deinterleave).
module tb_block_interleaver_wide;

  localparam int R  = 3;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int N  = R * C;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [DW-1:0] in_data;
  logic          in_empty;
  logic          in_re;
  logic [DW-1:0] out_data;
  logic          out_we;
  logic          out_full;
  logic          blk_end;

  always #5 clk = ~clk;

  block_interleaver_wide #(
    .ROW_NUMBER(R),
    .COL_NUMBER(C),
    .DATA_WIDTH(DW)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .MODE         (mode),
    .FIFO_IN_DATA (in_data),
    .FIFO_IN_EMPTY(in_empty),
    .FIFO_IN_RE   (in_re),
    .FIFO_OUT_DATA(out_data),
    .FIFO_OUT_WE  (out_we),
    .FIFO_OUT_FULL(out_full),
    .BLOCK_END    (blk_end)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // stimulus source and knobs
  logic [DW-1:0] src_q[$];
  logic          mode_q[$];
  bit            empty_toggle = 1'b0;
  bit            empty_phase  = 1'b0;
  bit            bp_on        = 1'b0;
  bit            mode_rand    = 1'b0;
  bit            strict_flow  = 1'b0;

  // reference model state
  logic [DW-1:0] cur_blk[$];
  logic          cur_mode;
  exp_t          exp_q[$];
  logic [DW-1:0] out_log[$];
  int            out_cnt      = 0;
  int            last_wr_cyc  = 0;
  int            first_we_cyc = 0;
  int            run_first_we = 0;
  int            last_we_cyc  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_block();
    logic [DW-1:0] arr [N];
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (cur_mode) arr[(k % R) * C + k / R] = cur_blk[k];
      else          arr[k] = cur_blk[(k % R) * C + k / R];
    end
    for (int j = 0; j < N; j++) begin
      e.data = arr[j];
      e.last = (j == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive();
    empty_phase = ~empty_phase;
    in_empty = (src_q.size() == 0) || (empty_toggle && empty_phase);
    in_data  = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
    if (cur_blk.size() == 0) mode = (mode_q.size() != 0) ? mode_q[0] : 1'b0;
    else if (mode_rand)      mode = 1'($urandom_range(0, 1));
    out_full = bp_on ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic tick();
    logic          consumed;
    logic          prev_full;
    logic          rst_edge;
    logic [DW-1:0] sym;
    logic          m;
    exp_t          e;
    #1;
    if (in_empty) check("re_while_empty", in_re, 1'b0);
    if (rst) check("re_in_reset", in_re, 1'b0);
    if (strict_flow && !rst) check("re_no_stall", in_re, !in_empty);
    consumed  = in_re;
    prev_full = out_full;
    rst_edge  = rst;
    sym       = in_data;
    m         = mode;
    @(posedge clk);
    cyc++;
    #1;
    if (rst_edge) begin
      cur_blk.delete();
      exp_q.delete();
      mode_q.delete();
      out_cnt = 0;
      check("rst_we", out_we, 1'b0);
      check("rst_block_end", blk_end, 1'b0);
      check("rst_data", out_data, '0);
    end else begin
      if (consumed === 1'b1) begin
        void'(src_q.pop_front());
        if (cur_blk.size() == 0) begin
          cur_mode = m;
          if (mode_q.size() != 0) void'(mode_q.pop_front());
        end
        cur_blk.push_back(sym);
        if (cur_blk.size() == N) begin
          model_block();
          cur_blk.delete();
          last_wr_cyc = cyc - 1;
        end
      end
      if (out_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("we_unexpected", out_we, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("block_end", blk_end, e.last);
          out_log.push_back(out_data);
          if (out_log.size() == 1) run_first_we = cyc;
          if (out_cnt == 0) first_we_cyc = cyc;
          out_cnt     = (out_cnt + 1) % N;
          last_we_cyc = cyc;
        end
      end else begin
        check("we_known", out_we, 1'b0);
        check("block_end_idle", blk_end, 1'b0);
      end
      if (prev_full) check("we_after_full", out_we, 1'b0);
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(src_q.size() + exp_q.size()), 0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic load_block(input logic m, input bit sequential, input bit deint_order);
    mode_q.push_back(m);
    for (int k = 0; k < N; k++) begin
      if (!sequential)      src_q.push_back(DW'($urandom));
      else if (deint_order) src_q.push_back(DW'((k % R) * C + k / R));
      else                  src_q.push_back(DW'(k));
    end
  endtask

  initial begin
    logic [DW-1:0] ref_il [N];
    int n;
    ref_il = '{8'd0, 8'd4, 8'd8, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd10, 8'd3, 8'd7, 8'd11};

    // Reset state, with symbols already waiting at the input.
    rst = 1'b1;
    load_block(1'b0, 1'b1, 1'b0);
    drive();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;

    // Interleave 0..11.
    strict_flow = 1'b1;
    out_log.delete();
    run_until_idle(100);
    check("il_count", 32'(out_log.size()), N);
    for (int i = 0; i < out_log.size() && i < N; i++) check("il_order", out_log[i], ref_il[i]);
    check("il_latency", 32'(first_we_cyc - last_wr_cyc), 2);

    // Deinterleave the interleaved sequence back to 0..11.
    out_log.delete();
    load_block(1'b1, 1'b1, 1'b1);
    drive();
    run_until_idle(100);
    check("deil_count", 32'(out_log.size()), N);
    for (int i = 0; i < out_log.size() && i < N; i++) check("deil_order", out_log[i], DW'(i));
    check("deil_latency", 32'(first_we_cyc - last_wr_cyc), 2);

    // Back-to-back blocks with alternating mode and mid-block MODE noise.
    out_log.delete();
    mode_rand = 1'b1;
    for (int b = 0; b < 4; b++) load_block(1'(b % 2), 1'b0, 1'b0);
    drive();
    run_until_idle(200);
    check("b2b_count", 32'(out_log.size()), 4 * N);
    check("b2b_no_bubble", 32'(last_we_cyc - run_first_we), 4 * N - 1);

    // Random output backpressure.
    out_log.delete();
    strict_flow = 1'b0;
    bp_on = 1'b1;
    for (int b = 0; b < 4; b++) load_block(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    drive();
    run_until_idle(600);
    check("bp_count", 32'(out_log.size()), 4 * N);
    bp_on = 1'b0;
    mode_rand = 1'b0;

    // Reset after 7 of 12 symbols.
    load_block(1'b0, 1'b0, 1'b0);
    drive();
    n = 0;
    while (cur_blk.size() < 7 && n < 50) begin tick(); n++; end
    check("partial_fill", 32'(cur_blk.size()), 7);
    rst = 1'b1;
    src_q.delete();
    drive();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset during readout.
    out_log.delete();
    load_block(1'b1, 1'b0, 1'b0);
    drive();
    n = 0;
    while (out_log.size() < 5 && n < 60) begin tick(); n++; end
    check("readout_started", 32'(out_log.size()), 5);
    rst = 1'b1;
    src_q.delete();
    drive();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Fresh block after reset.
    out_log.delete();
    load_block(1'b0, 1'b1, 1'b0);
    drive();
    run_until_idle(100);
    check("post_rst_count", 32'(out_log.size()), N);
    for (int i = 0; i < out_log.size() && i < N; i++) check("post_rst_order", out_log[i], ref_il[i]);

    // Input FIFO empty on every other cycle.
    out_log.delete();
    empty_toggle = 1'b1;
    load_block(1'b0, 1'b1, 1'b0);
    drive();
    run_until_idle(150);
    check("empty_tog_count", 32'(out_log.size()), N);
    for (int i = 0; i < out_log.size() && i < N; i++) check("empty_tog_order", out_log[i], ref_il[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
